eth_link_sup: RTL and testbench
===============================

# eth_link_sup

Link bring-up supervisor for the 10G Ethernet transceiver path. It sits directly downstream of the transceiver reset controller and consumes that controller's `tx_ready`, `rx_ready` and `rx_is_lockedtodata` together with PCS `block_lock`. It drives the controller's `reset` input in a closed loop: it re-pulses the reset when the link fails to come up within a timeout. It publishes a debounced `link_up` to the MAC/PTP logic.

## Interface
Parameters:
- `RST_PULSE_CYC`, 16: cycles `xcvr_reset` is held high per reset attempt (≥1).
- `STABLE_CYC`, 1024: consecutive cycles of lock required before `link_up` (≥1).
- `TIMEOUT_CYC`, 1000000: cycles allowed from leaving RESET_HOLD to reaching LINK_UP (must be > `STABLE_CYC`).

Ports:
- `clock`, in, 1: sole clock. Reset controller outputs are synchronous to it.
- `reset`, in, 1: synchronous, active-high.
- `tx_ready`, in, 1: from reset controller, synchronous.
- `rx_ready`, in, 1: from reset controller, synchronous.
- `rx_is_lockedtodata`, in, 1: CDR lock, asynchronous.
- `block_lock`, in, 1: PCS block lock, asynchronous.
- `force_retrain`, in, 1: single-cycle request to restart bring-up.
- `xcvr_reset`, out, 1: drives reset controller `reset`.
- `link_up`, out, 1: qualified link status.
- `retry_count`, out, 8: timeout-triggered retries, saturating.
- `state`, out, 2: current FSM state, for debug/CSR.

## Operation
- `rx_is_lockedtodata` and `block_lock` each pass through a 2-flop synchronizer. `lock_s` is the AND of both synchronized values.
- One cycle counter `cnt` and one timeout counter `tmo`. Both are wide enough for `TIMEOUT_CYC`.
- FSM states, with encodings:
  - RESET_HOLD=0: `xcvr_reset`=1. `cnt` counts. After exactly `RST_PULSE_CYC` cycles → WAIT_READY, with `tmo` cleared.
  - WAIT_READY=1: waits for `tx_ready`&`rx_ready`=1; when sampled → WAIT_LOCK with `cnt` cleared.
  - WAIT_LOCK=2: `cnt` increments while `lock_s`=1 and clears when 0. When `cnt` reaches `STABLE_CYC` → LINK_UP. If `tx_ready` or `rx_ready` drops → WAIT_READY.
  - LINK_UP=3: `link_up`=1.
    - `lock_s` drop → WAIT_LOCK, with no reset, `cnt` cleared and `tmo` cleared.
    - `tx_ready` or `rx_ready` drop → RESET_HOLD.
- `tmo` increments every cycle in WAIT_READY and WAIT_LOCK. It is not cleared by a WAIT_LOCK→WAIT_READY move.
  - At `tmo`=`TIMEOUT_CYC` → RESET_HOLD, and `retry_count` increments (saturates at 255).
- `force_retrain`=1 in any state → RESET_HOLD, with `retry_count` unchanged. In RESET_HOLD it restarts the pulse count.
- Priority when events coincide: `force_retrain` > ready loss > stable-lock completion > timeout. A completion and a timeout on the same cycle go to LINK_UP.
- `retry_count` clears only on `reset`.

## Timing
- Reset values: `xcvr_reset`=1, `link_up`=0, `retry_count`=0, `state`=0 (RESET_HOLD), counters=0, synchronizer flops=0.
- All outputs are registered and reflect the state one cycle after the transition edge.
- `xcvr_reset` high duration: exactly `RST_PULSE_CYC` cycles after `reset` deasserts or after a retry decision.
- Lock latency: from both async lock inputs rising (stable) to `link_up`=1 is 2 sync cycles + `STABLE_CYC` + 1 cycles, given ready is already high.
- Loss latency:
  - `tx_ready`/`rx_ready` drop → `link_up`=0 one cycle later.
  - Lock drop → `link_up`=0 three cycles later.
- `reset` asserted mid-operation: all registers take their reset values on the next edge, regardless of state.

## Structure
- Package `eth_link_pkg`: state encoding constants or enum (`ST_RESET_HOLD`..`ST_LINK_UP`) and the `retry_count` width constant (8). Shared with the CSR block.
- Sub-module `eth_sync2`: 2-flop synchronizer with parameterized width, reset to 0. Instantiated once at width 2.
- Everything else is flat in `eth_link_sup`. Target is about 150–250 lines of RTL.

## Test plan
Bench parameters: `RST_PULSE_CYC`=4, `STABLE_CYC`=16, `TIMEOUT_CYC`=200.

- Release `reset` → `xcvr_reset` high for exactly 4 cycles, then low. `state`=1.
- Raise both ready, then both locks, held → `link_up`=1 exactly 2+16+1 cycles after the locks rise. `retry_count`=0.
- Ready never rises → `xcvr_reset` re-pulses 4 cycles every 204 cycles. `retry_count` = 1, 2, 3…
  - Force 300 timeouts → `retry_count` holds at 255.
- In LINK_UP, glitch `block_lock` low for 1 cycle → `link_up` falls 3 cycles later and `xcvr_reset` stays 0. `link_up` returns 16 cycles after lock is restable (plus sync latency).
- In LINK_UP, drop `rx_ready` → next cycle `link_up`=0, `xcvr_reset`=1 for 4 cycles.
- Pulse `force_retrain` on the same cycle as stable completion → RESET_HOLD, `link_up` stays 0, `retry_count` unchanged. Assert `reset` mid-WAIT_LOCK → all outputs at reset values next cycle.

Source files
------------

// File: rtl/eth_link_pkg.sv
// Shared definitions for the Ethernet link supervisor and its CSR view.
// State encodings are visible on the debug/CSR state field, so keep them stable.
package eth_link_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_WAIT_LOCK  = 2'd2,
    ST_LINK_UP    = 2'd3
  } link_st_t;

endpackage

// File: rtl/eth_sync2.sv
// Purpose: two-flop synchronizer for asynchronous level signals, cleared by reset.
// Latency: 2 clock cycles from input change to output change.
// Backpressure: none; free-running level path.
module eth_sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives a settled copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_link_sup.sv
// Purpose: closed-loop transceiver bring-up supervisor with retry and debounced link_up.
// Latency: ready loss -> link_up low 1 cycle; lock loss 3 cycles; lock gain 2+STABLE_CYC+1 cycles.
// Backpressure: none; status inputs are levels and outputs are registered levels.
module eth_link_sup
  import eth_link_pkg::*;
#(
  parameter int RST_PULSE_CYC = 16,
  parameter int STABLE_CYC    = 1024,
  parameter int TIMEOUT_CYC   = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tx_ready,
  input  logic               rx_ready,
  input  logic               rx_is_lockedtodata,
  input  logic               block_lock,
  input  logic               force_retrain,
  output logic               xcvr_reset,
  output logic               link_up,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  link_st_t      st;
  logic [TW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [1:0]    lock_sync;
  logic          lock_s;
  logic          rdy;
  logic          pulse_done;
  logic          stable_done;
  logic          tmo_hit;

  eth_sync2 #(.W(2)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({rx_is_lockedtodata, block_lock}),
    .q     (lock_sync)
  );

  assign lock_s      = &lock_sync;
  assign rdy         = tx_ready & rx_ready;
  assign pulse_done  = (cnt == TW'(RST_PULSE_CYC - 1));
  assign stable_done = (cnt == TW'(STABLE_CYC));
  // tmo is the count before this cycle's increment, so this fires on the cycle
  // that would bring it to TIMEOUT_CYC. >= keeps it sticky if a ready-loss move
  // ever carries tmo past the threshold.
  assign tmo_hit     = (tmo >= TW'(TIMEOUT_CYC - 1));
  assign state       = st;

  // Bring-up FSM; outputs are registered alongside the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_RESET_HOLD;
      cnt         <= '0;
      tmo         <= '0;
      xcvr_reset  <= 1'b1;
      link_up     <= 1'b0;
      retry_count <= '0;
    end else if (force_retrain) begin
      st         <= ST_RESET_HOLD;
      cnt        <= '0;
      xcvr_reset <= 1'b1;
      link_up    <= 1'b0;
    end else begin
      case (st)
        ST_RESET_HOLD: begin
          if (pulse_done) begin
            st         <= ST_WAIT_READY;
            cnt        <= '0;
            tmo        <= '0;
            xcvr_reset <= 1'b0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ST_WAIT_READY: begin
          if (tmo_hit) begin
            st         <= ST_RESET_HOLD;
            cnt        <= '0;
            xcvr_reset <= 1'b1;
            if (retry_count != '1) retry_count <= retry_count + RETRY_W'(1);
          end else begin
            tmo <= tmo + TW'(1);
            if (rdy) begin
              st  <= ST_WAIT_LOCK;
              cnt <= '0;
            end
          end
        end
        ST_WAIT_LOCK: begin
          if (!rdy) begin
            st  <= ST_WAIT_READY;
            cnt <= '0;
            tmo <= tmo + TW'(1);
          end else if (stable_done) begin
            st      <= ST_LINK_UP;
            link_up <= 1'b1;
          end else if (tmo_hit) begin
            st         <= ST_RESET_HOLD;
            cnt        <= '0;
            xcvr_reset <= 1'b1;
            if (retry_count != '1) retry_count <= retry_count + RETRY_W'(1);
          end else begin
            tmo <= tmo + TW'(1);
            cnt <= lock_s ? cnt + TW'(1) : '0;
          end
        end
        ST_LINK_UP: begin
          if (!rdy) begin
            st         <= ST_RESET_HOLD;
            cnt        <= '0;
            xcvr_reset <= 1'b1;
            link_up    <= 1'b0;
          end else if (!lock_s) begin
            st      <= ST_WAIT_LOCK;
            cnt     <= '0;
            tmo     <= '0;
            link_up <= 1'b0;
          end
        end
        default: begin
          st         <= ST_RESET_HOLD;
          cnt        <= '0;
          xcvr_reset <= 1'b1;
          link_up    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_link_sup.sv
// Purpose: scoreboard bench for eth_link_sup; expected output changes are queued with their cycle.
// Latency: each queued entry names the exact clock edge after which the outputs must change.
// Backpressure: none; the monitor pops one entry per observed output change.
module tb_eth_link_sup;

  localparam int RST = 4;
  localparam int STB = 16;
  localparam int TMO = 200;
  localparam int PER = RST + TMO;
  localparam int NTMO = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_ready = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_is_lockedtodata = 1'b0;
  logic       block_lock = 1'b0;
  logic       force_retrain = 1'b0;
  logic       xcvr_reset;
  logic       link_up;
  logic [7:0] retry_count;
  logic [1:0] state;

  eth_link_sup #(
    .RST_PULSE_CYC (RST),
    .STABLE_CYC    (STB),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .tx_ready           (tx_ready),
    .rx_ready           (rx_ready),
    .rx_is_lockedtodata (rx_is_lockedtodata),
    .block_lock         (block_lock),
    .force_retrain      (force_retrain),
    .xcvr_reset         (xcvr_reset),
    .link_up            (link_up),
    .retry_count        (retry_count),
    .state              (state)
  );

  always #5 clock = ~clock;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [11:0] vec;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void push_exp(int c, logic xr, logic lu, logic [1:0] st, logic [7:0] rc);
    exp_t e;
    e.cyc = c;
    e.vec = {xr, lu, st, rc};
    q.push_back(e);
  endfunction

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor: every change of {xcvr_reset, link_up, state, retry_count} must match the queue head.
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    exp_t e;
    prev = 12'hfff;
    forever begin
      @(negedge clock);
      cur = {xcvr_reset, link_up, state, retry_count};
      if (cur !== prev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got xr=%b lu=%b st=%0d rc=%0d",
                   cyc, cur[11], cur[10], cur[9:8], cur[7:0]);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.vec !== cur) begin
            fails++;
            $display("FAIL event got cyc=%0d xr=%b lu=%b st=%0d rc=%0d, required cyc=%0d xr=%b lu=%b st=%0d rc=%0d",
                     cyc, cur[11], cur[10], cur[9:8], cur[7:0],
                     e.cyc, e.vec[11], e.vec[10], e.vec[9:8], e.vec[7:0]);
          end
        end
        prev = cur;
      end
    end
  end

  // Stimulus: directed phases, each pushing its hand-derived output changes.
  initial begin
    int t;
    int lk;
    int g;
    int d;
    int w;
    logic [7:0] rc;

    // Reset state visible after the first edge.
    push_exp(1, 1'b1, 1'b0, 2'd0, 8'd0);
    wait_until(2);

    // Release reset: four cycles of xcvr_reset, then WAIT_READY.
    reset = 1'b0;
    t = cyc;
    push_exp(t + RST, 1'b0, 1'b0, 2'd1, 8'd0);
    wait_until(t + 6);

    // Ready, then locks: link_up 2+16+1 edges after the locks rise.
    t = cyc;
    tx_ready = 1'b1;
    rx_ready = 1'b1;
    push_exp(t + 1, 1'b0, 1'b0, 2'd2, 8'd0);
    wait_until(t + 3);
    lk = cyc;
    rx_is_lockedtodata = 1'b1;
    block_lock = 1'b1;
    push_exp(lk + 2 + STB + 1, 1'b0, 1'b1, 2'd3, 8'd0);

    // One-cycle block_lock glitch: drop after 3 edges, recover without reset.
    wait_until(lk + 25);
    g = cyc;
    block_lock = 1'b0;
    push_exp(g + 3, 1'b0, 1'b0, 2'd2, 8'd0);
    push_exp(g + 1 + 2 + STB + 1, 1'b0, 1'b1, 2'd3, 8'd0);
    wait_until(g + 1);
    block_lock = 1'b1;

    // Ready loss from LINK_UP; a force_retrain inside RESET_HOLD restarts the pulse.
    wait_until(g + 25);
    d = cyc;
    tx_ready = 1'b0;
    rx_ready = 1'b0;
    push_exp(d + 1, 1'b1, 1'b0, 2'd0, 8'd0);
    push_exp(d + 7, 1'b0, 1'b0, 2'd1, 8'd0);
    wait_until(d + 2);
    force_retrain = 1'b1;
    wait_until(d + 3);
    force_retrain = 1'b0;

    // Ready never returns: re-pulse every PER cycles, retry_count saturates at 255.
    w = d + 7;
    for (int i = 1; i <= NTMO; i++) begin
      rc = (i > 255) ? 8'd255 : 8'(i);
      push_exp(w + PER * (i - 1) + TMO, 1'b1, 1'b0, 2'd0, rc);
      push_exp(w + PER * i, 1'b0, 1'b0, 2'd1, rc);
    end
    wait_until(w + PER * NTMO + 2);

    // force_retrain coincident with stable completion wins; retry_count untouched.
    t = cyc;
    tx_ready = 1'b1;
    rx_ready = 1'b1;
    push_exp(t + 1, 1'b0, 1'b0, 2'd2, 8'd255);
    wait_until(t + 1 + STB);
    force_retrain = 1'b1;
    push_exp(t + 2 + STB, 1'b1, 1'b0, 2'd0, 8'd255);
    push_exp(t + 2 + STB + RST, 1'b0, 1'b0, 2'd1, 8'd255);
    push_exp(t + 3 + STB + RST, 1'b0, 1'b0, 2'd2, 8'd255);
    wait_until(t + 2 + STB);
    force_retrain = 1'b0;

    // Reset mid-WAIT_LOCK: reset values next edge, then a clean bring-up.
    wait_until(t + 26);
    reset = 1'b1;
    push_exp(t + 27, 1'b1, 1'b0, 2'd0, 8'd0);
    wait_until(t + 28);
    reset = 1'b0;
    push_exp(t + 28 + RST, 1'b0, 1'b0, 2'd1, 8'd0);
    push_exp(t + 29 + RST, 1'b0, 1'b0, 2'd2, 8'd0);
    push_exp(t + 30 + RST + STB, 1'b0, 1'b1, 2'd3, 8'd0);
    wait_until(t + 60);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_events got %0d outstanding, required 0 (next cyc=%0d)",
               q.size(), q[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
